display_page_scheduler: RTL and testbench

//  Shares the single 4-digit seven-segment display between NPAGE data pages (steps, miles,

---
 rtl/display_page_scheduler_pkg.sv | 23 ++
 rtl/next_enabled_page.sv | 38 +++
 rtl/display_page_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_display_page_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_page_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// display_sched_pkg
// Purpose : Shared types and default sizing for the display page scheduler and
//           the digit-multiplex driver that consumes its output.
// Contents: state_e     - scheduler state (BLANK / SHOW / ALERT)
//           page_idx_t  - page index for the default page count
//           NPAGE_DEF, VAL_W_DEF, PAGE_W_DEF - default sizing constants
// -----------------------------------------------------------------------------
package display_sched_pkg;

  localparam int NPAGE_DEF  = 4;
  localparam int VAL_W_DEF  = 14;
  localparam int PAGE_W_DEF = $clog2(NPAGE_DEF);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_SHOW  = 2'd1,
    ST_ALERT = 2'd2
  } state_e;

  typedef logic [PAGE_W_DEF-1:0] page_idx_t;

endpackage

// File: rtl/next_enabled_page.sv
// -----------------------------------------------------------------------------
// next_enabled_page
// Purpose : Combinational circular search for the next enabled page.
// Ports   : mask  [NPAGE]  in  - per-page enable bits
//           start [PW]     in  - search origin (checked last)
//           idx   [PW]     out - first set bit strictly after start, circular
//           found          out - 1 when any mask bit is set
// -----------------------------------------------------------------------------
module next_enabled_page
  import display_sched_pkg::*;
#(
  parameter int NPAGE = NPAGE_DEF,
  parameter int PW    = $clog2(NPAGE)
) (
  input  logic [NPAGE-1:0] mask,
  input  logic [PW-1:0]    start,
  output logic [PW-1:0]    idx,
  output logic             found
);

  // Scan from farthest to nearest so the nearest hit after start wins;
  // start itself is the farthest (k == NPAGE) and therefore lowest priority.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NPAGE; k >= 1; k--) begin
      int j;
      j = (int'(start) + k) % NPAGE;
      if (mask[j]) begin
        idx   = PW'(j);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/display_page_scheduler.sv
// -----------------------------------------------------------------------------
// display_page_scheduler
// Purpose : Shares one 4-digit display between NPAGE rotating data pages and a
//           preemptive alert source. Pages rotate on a dwell timer; an alert
//           rising edge preempts rotation and the rotation resumes afterwards.
// Ports   : CLK, RESET_N (async active-low)
//           tick_in    - one-cycle time-base strobe
//           page_en    - per-page rotation enable
//           page_vals  - packed page values, page i at [i*VAL_W +: VAL_W]
//           alert_req  - level, rising edge starts an alert
//           alert_val  - value shown while alerting
//           disp_value/disp_page/disp_alert/disp_blank - registered display
//           disp_load  - one-cycle pulse when the shown source changes
// -----------------------------------------------------------------------------
module display_page_scheduler
  import display_sched_pkg::*;
#(
  parameter int NPAGE       = NPAGE_DEF,
  parameter int VAL_W       = VAL_W_DEF,
  parameter int DWELL_TICKS = 2000,
  parameter int ALERT_TICKS = 3000,
  parameter int CNT_W       = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   tick_in,
  input  logic [NPAGE-1:0]       page_en,
  input  logic [NPAGE*VAL_W-1:0] page_vals,
  input  logic                   alert_req,
  input  logic [VAL_W-1:0]       alert_val,
  output logic [VAL_W-1:0]       disp_value,
  output logic [$clog2(NPAGE)-1:0] disp_page,
  output logic                   disp_alert,
  output logic                   disp_blank,
  output logic                   disp_load
);

  localparam int PW = $clog2(NPAGE);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] ALERT_LAST = CNT_W'(ALERT_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    cur_q, cur_d;
  logic [PW-1:0]    ret_q, ret_d;
  logic             ret_vld_q, ret_vld_d;
  logic             alert_q;
  logic             load_d;

  logic [VAL_W-1:0] disp_value_q, disp_value_d;
  logic [PW-1:0]    disp_page_q;
  logic             disp_alert_q, disp_blank_q, disp_load_q;

  logic             rise_s;
  logic             any_en_s;
  logic [PW-1:0]    nxt_start_s;
  logic [PW-1:0]    nxt_idx_s;
  logic             nxt_found_s;

  assign rise_s   = alert_req & ~alert_q;
  assign any_en_s = |page_en;

  // Search origin: current page while showing, the saved page on alert exit,
  // otherwise the last index so the search yields the lowest enabled page.
  always_comb begin
    nxt_start_s = PW'(NPAGE - 1);
    case (state_q)
      ST_SHOW:  nxt_start_s = cur_q;
      ST_ALERT: nxt_start_s = ret_vld_q ? ret_q : PW'(NPAGE - 1);
      default:  nxt_start_s = PW'(NPAGE - 1);
    endcase
  end

  next_enabled_page #(
    .NPAGE (NPAGE),
    .PW    (PW)
  ) u_next (
    .mask  (page_en),
    .start (nxt_start_s),
    .idx   (nxt_idx_s),
    .found (nxt_found_s)
  );

  // Next-state logic: alert rise has priority over every rotation event.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    ret_d     = ret_q;
    ret_vld_d = ret_vld_q;
    load_d    = 1'b0;
    if (rise_s) begin
      state_d = ST_ALERT;
      cnt_d   = '0;
      if (state_q != ST_ALERT) begin
        ret_d     = cur_q;
        ret_vld_d = (state_q == ST_SHOW);
        load_d    = 1'b1;
      end else begin
        ret_d     = ret_q;
      end
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (nxt_found_s) begin
            state_d = ST_SHOW;
            cur_d   = nxt_idx_s;
            cnt_d   = '0;
            load_d  = 1'b1;
          end else begin
            state_d = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (!any_en_s) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            load_d  = 1'b1;
          end else if (!page_en[cur_q]) begin
            cur_d  = nxt_idx_s;
            cnt_d  = '0;
            load_d = 1'b1;
          end else if (tick_in) begin
            // Compare with >= so a stale count can never run past the limit.
            if (cnt_q >= DWELL_LAST) begin
              cnt_d  = '0;
              cur_d  = nxt_idx_s;
              load_d = (nxt_idx_s != cur_q);
            end else begin
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_ALERT: begin
          if (tick_in && (cnt_q >= ALERT_LAST)) begin
            cnt_d  = '0;
            load_d = 1'b1;
            if (ret_vld_q && page_en[ret_q]) begin
              state_d = ST_SHOW;
              cur_d   = ret_q;
            end else if (nxt_found_s) begin
              state_d = ST_SHOW;
              cur_d   = nxt_idx_s;
            end else begin
              state_d = ST_BLANK;
            end
          end else if (tick_in) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Displayed value follows the live source of the next state.
  always_comb begin
    disp_value_d = '0;
    case (state_d)
      ST_SHOW:  disp_value_d = page_vals[VAL_W*int'(cur_d) +: VAL_W];
      ST_ALERT: disp_value_d = alert_val;
      default:  disp_value_d = '0;
    endcase
  end

  // State, counter, alert edge register and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      cur_q        <= '0;
      ret_q        <= '0;
      ret_vld_q    <= 1'b0;
      alert_q      <= 1'b0;
      disp_value_q <= '0;
      disp_page_q  <= '0;
      disp_alert_q <= 1'b0;
      disp_blank_q <= 1'b1;
      disp_load_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      ret_q        <= ret_d;
      ret_vld_q    <= ret_vld_d;
      alert_q      <= alert_req;
      disp_value_q <= disp_value_d;
      disp_page_q  <= cur_d;
      disp_alert_q <= (state_d == ST_ALERT);
      disp_blank_q <= (state_d == ST_BLANK);
      disp_load_q  <= load_d;
    end
  end

  assign disp_value = disp_value_q;
  assign disp_page  = disp_page_q;
  assign disp_alert = disp_alert_q;
  assign disp_blank = disp_blank_q;
  assign disp_load  = disp_load_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_page_scheduler
// Directed stimulus with a source-level reference model compared every cycle,
// plus hand-computed literal checks at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_display_page_scheduler;

  localparam int NPAGE = 4;
  localparam int VAL_W = 14;
  localparam int DWELL = 4;
  localparam int ALRT  = 5;

  logic                   CLK = 1'b0;
  logic                   RESET_N;
  logic                   tick_in;
  logic [NPAGE-1:0]       page_en;
  logic [NPAGE*VAL_W-1:0] page_vals;
  logic                   alert_req;
  logic [VAL_W-1:0]       alert_val;
  logic [VAL_W-1:0]       disp_value;
  logic [1:0]             disp_page;
  logic                   disp_alert;
  logic                   disp_blank;
  logic                   disp_load;

  int total = 0;
  int bad   = 0;
  int load_cnt = 0;
  int base;
  int pv [0:3] = '{1234, 2345, 3456, 4567};

  display_page_scheduler #(
    .NPAGE(NPAGE), .VAL_W(VAL_W), .DWELL_TICKS(DWELL), .ALERT_TICKS(ALRT), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .tick_in(tick_in), .page_en(page_en),
    .page_vals(page_vals), .alert_req(alert_req), .alert_val(alert_val),
    .disp_value(disp_value), .disp_page(disp_page), .disp_alert(disp_alert),
    .disp_blank(disp_blank), .disp_load(disp_load)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_en(input logic [3:0] m, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (m[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  // Reference model: what source the display should show (0 blank, 1 page, 2 alert)
  int m_mode, m_page, m_ticks, m_ret;
  bit m_prev, m_retv;
  int e_value, e_page;
  bit e_alert, e_blank, e_load;

  always @(posedge CLK or negedge RESET_N) begin : model
    int md, pg, tk, rp, np;
    bit rv, ld, rise;
    if (!RESET_N) begin
      m_mode <= 0; m_page <= 0; m_ticks <= 0; m_ret <= 0; m_prev <= 1'b0; m_retv <= 1'b0;
      e_value <= 0; e_page <= 0; e_alert <= 1'b0; e_blank <= 1'b1; e_load <= 1'b0;
    end else begin
      md = m_mode; pg = m_page; tk = m_ticks; rp = m_ret; rv = m_retv; ld = 1'b0;
      rise = alert_req && !m_prev;
      if (rise) begin
        if (md != 2) begin rp = pg; rv = (md == 1); ld = 1'b1; end
        md = 2; tk = 0;
      end else if (md == 0) begin
        if (page_en != 4'b0000) begin md = 1; pg = next_en(page_en, 3); tk = 0; ld = 1'b1; end
      end else if (md == 1) begin
        if (page_en == 4'b0000) begin md = 0; tk = 0; ld = 1'b1; end
        else if (!page_en[pg]) begin pg = next_en(page_en, pg); tk = 0; ld = 1'b1; end
        else if (tick_in) begin
          tk++;
          if (tk == DWELL) begin
            tk = 0; np = next_en(page_en, pg); ld = (np != pg); pg = np;
          end
        end
      end else begin
        if (tick_in) begin
          tk++;
          if (tk == ALRT) begin
            tk = 0; ld = 1'b1;
            if (rv && page_en[rp]) begin md = 1; pg = rp; end
            else if (page_en != 4'b0000) begin md = 1; pg = rv ? next_en(page_en, rp) : next_en(page_en, 3); end
            else md = 0;
          end
        end
      end
      m_mode <= md; m_page <= pg; m_ticks <= tk; m_ret <= rp; m_retv <= rv; m_prev <= alert_req;
      e_value <= (md == 2) ? int'(alert_val) : (md == 1) ? pv[pg] : 0;
      e_page  <= pg;
      e_alert <= (md == 2);
      e_blank <= (md == 0);
      e_load  <= ld;
    end
  end

  // Compare process: every falling edge while out of reset.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      chk("cyc_value", int'(disp_value), e_value);
      chk("cyc_page",  int'(disp_page),  e_page);
      chk("cyc_alert", int'(disp_alert), int'(e_alert));
      chk("cyc_blank", int'(disp_blank), int'(e_blank));
      chk("cyc_load",  int'(disp_load),  int'(e_load));
      if (disp_load) load_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin tick_in = 1'b1; cyc(1); tick_in = 1'b0; end
  endtask

  initial begin
    RESET_N = 1'b0; tick_in = 1'b0; page_en = 4'b0000; alert_req = 1'b0;
    alert_val = 14'd777;
    page_vals = {14'd4567, 14'd3456, 14'd2345, 14'd1234};
    #12;
    chk("rst_blank", int'(disp_blank), 1);
    chk("rst_value", int'(disp_value), 0);
    chk("rst_load",  int'(disp_load), 0);
    @(posedge CLK); #2; RESET_N = 1'b1;
    cyc(2);
    chk("idle_blank", int'(disp_blank), 1);

    // Full rotation 0,1,2,3,0
    page_en = 4'b1111; base = load_cnt; cyc(1);
    chk("rot_first_page", int'(disp_page), 0);
    chk("rot_first_val",  int'(disp_value), 1234);
    chk("rot_first_load", int'(disp_load), 1);
    ticks(4);
    chk("rot_p1", int'(disp_page), 1);
    chk("rot_p1_val", int'(disp_value), 2345);
    ticks(12);
    chk("rot_back_p0", int'(disp_page), 0);
    cyc(1);
    chk("rot_loads", load_cnt - base, 5);

    // Sparse rotation and enable drop
    page_en = 4'b1010; cyc(1);
    chk("sparse_p1", int'(disp_page), 1);
    ticks(4);
    chk("sparse_p3", int'(disp_page), 3);
    page_en = 4'b0010; cyc(1);
    chk("drop_to_p1", int'(disp_page), 1);

    // Sole page: no pulses across expiries
    page_en = 4'b0100; cyc(2);
    chk("sole_p2", int'(disp_page), 2);
    base = load_cnt; ticks(12); cyc(1);
    chk("sole_p2_hold", int'(disp_page), 2);
    chk("sole_no_load", load_cnt - base, 0);

    // Alert on page 1 after 2 ticks
    page_en = 4'b0010; cyc(1);
    page_en = 4'b1010; ticks(2);
    alert_req = 1'b1; cyc(1);
    chk("al_on", int'(disp_alert), 1);
    chk("al_val", int'(disp_value), 777);
    chk("al_page_held", int'(disp_page), 1);
    ticks(4);
    chk("al_still", int'(disp_alert), 1);
    ticks(1);
    chk("al_exit", int'(disp_alert), 0);
    chk("al_ret_p1", int'(disp_page), 1);
    chk("al_ret_val", int'(disp_value), 2345);
    ticks(3);
    chk("al_fresh_dwell", int'(disp_page), 1);
    ticks(1);
    chk("al_after_p3", int'(disp_page), 3);
    chk("al_held_no_retrig", int'(disp_alert), 0);
    alert_req = 1'b0; cyc(1);

    // Alert rise coincident with dwell expiry on page 0
    page_en = 4'b0001; cyc(1);
    page_en = 4'b1111; ticks(3);
    tick_in = 1'b1; alert_req = 1'b1; cyc(1); tick_in = 1'b0;
    chk("coinc_alert", int'(disp_alert), 1);
    chk("coinc_page", int'(disp_page), 0);
    ticks(5);
    chk("coinc_ret_p0", int'(disp_page), 0);
    ticks(3);
    chk("coinc_dwell_p0", int'(disp_page), 0);
    ticks(1);
    chk("coinc_next_p1", int'(disp_page), 1);
    alert_req = 1'b0;

    // Blank, alert from blank, reset mid-alert
    page_en = 4'b0000; cyc(1);
    chk("to_blank", int'(disp_blank), 1);
    chk("to_blank_load", int'(disp_load), 1);
    alert_req = 1'b1; cyc(1);
    chk("blank_alert", int'(disp_alert), 1);
    chk("blank_alert_nb", int'(disp_blank), 0);
    ticks(2); page_en = 4'b0100; ticks(3);
    chk("blank_alert_exit_p2", int'(disp_page), 2);
    alert_req = 1'b0; cyc(1); alert_req = 1'b1; cyc(1);
    chk("al2_on", int'(disp_alert), 1);
    alert_req = 1'b0; RESET_N = 1'b0; #1;
    chk("arst_alert", int'(disp_alert), 0);
    chk("arst_blank", int'(disp_blank), 1);
    chk("arst_value", int'(disp_value), 0);
    chk("arst_page",  int'(disp_page), 0);
    chk("arst_load",  int'(disp_load), 0);
    cyc(2); RESET_N = 1'b1; cyc(3);
    chk("post_rst_p2", int'(disp_page), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
